sprite_layer_arbiter: RTL and testbench

Time-multiplexes one shared sprite ROM/palette-index path among NUM_LAYERS sprite layers for each screen pixel. On a pixel request it fetches palette indices layer by layer in priority order and stops at the first opaque index. It then presents the winning 4-bit index and layer number to the downstream colour palette lookup. It sits between the sprite position/hit logic and the on-chip sprite memory plus colour palette.

---
 rtl/sprite_layer_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sprite_layer_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_arbiter.sv
// Sprite layer arbiter: resolves one pixel by fetching layer palette indices in priority
// order through one shared ROM port, stopping at the first opaque index. SPRITE_ARB_DROP_CNT_EN adds drop_cnt.
module sprite_layer_arbiter #(
    parameter int                NUM_LAYERS      = 4,
    parameter int                ADDR_W          = 10,
    parameter int                IDX_W           = 4,
    parameter int                ROM_LAT         = 1,
    parameter logic [IDX_W-1:0]  TRANSPARENT_IDX = 4'hB,
    localparam int               LAYER_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           pix_req,
    input  logic [NUM_LAYERS-1:0]          layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_addr,
    output logic                           rom_rd,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [IDX_W-1:0]               rom_idx,
    output logic                           pix_valid,
    output logic                           pix_opaque,
    output logic [IDX_W-1:0]               pal_idx,
    output logic [LAYER_W-1:0]             pal_layer,
    output logic                           busy,
    output logic                           req_drop
`ifdef SPRITE_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam int CNT_W = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_LAYERS-1:0]          mask_q, mask_d;
    logic [NUM_LAYERS*ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           opaque_q, opaque_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [LAYER_W-1:0]             layer_q, layer_d;

    logic [LAYER_W-1:0]             sel_layer;
    logic [ADDR_W-1:0]              sel_addr;
    logic [NUM_LAYERS-1:0]          mask_clr;
    logic                           last_wait;

    // Highest-priority pending layer is the lowest set mask bit.
    always_comb begin
        sel_layer = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_layer = LAYER_W'(i);
        end
    end

    assign sel_addr  = addr_q[int'(sel_layer) * ADDR_W +: ADDR_W];
    assign mask_clr  = mask_q & (mask_q - NUM_LAYERS'(1));
    assign last_wait = (cnt_q == CNT_W'(ROM_LAT - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        opaque_d  = opaque_q;
        idx_d     = idx_q;
        layer_d   = layer_q;
        rom_rd    = 1'b0;
        rom_addr  = '0;
        pix_valid = 1'b0;
        busy      = 1'b0;
        req_drop  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                pix_valid = (state_q == S_DONE);
                state_d   = S_IDLE;
                if (pix_req) begin
                    mask_d = layer_hit;
                    addr_d = layer_addr;
                    if (|layer_hit) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d  = S_DONE;
                        opaque_d = 1'b0;
                        idx_d    = TRANSPARENT_IDX;
                        layer_d  = '0;
                    end
                end
            end

            S_ISSUE: begin
                busy     = 1'b1;
                req_drop = pix_req;
                rom_rd   = 1'b1;
                rom_addr = sel_addr;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                busy     = 1'b1;
                req_drop = pix_req;
                if (!last_wait) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (rom_idx != TRANSPARENT_IDX) begin
                    opaque_d = 1'b1;
                    idx_d    = rom_idx;
                    layer_d  = sel_layer;
                    state_d  = S_DONE;
                end else begin
                    mask_d = mask_clr;
                    if (|mask_clr) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d  = S_DONE;
                        opaque_d = 1'b0;
                        idx_d    = TRANSPARENT_IDX;
                        layer_d  = '0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            // NOTE: the latched address bank is small and reset with everything else; it is never read before a request loads it.
            addr_q   <= '0;
            cnt_q    <= '0;
            opaque_q <= 1'b0;
            idx_q    <= TRANSPARENT_IDX;
            layer_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            opaque_q <= opaque_d;
            idx_q    <= idx_d;
            layer_q  <= layer_d;
        end
    end

    assign pix_opaque = opaque_q;
    assign pal_idx    = idx_q;
    assign pal_layer  = layer_q;

`ifdef SPRITE_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (req_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Bench for sprite_layer_arbiter: two instances (ROM_LAT=1 and ROM_LAT=2) share stimulus and
// are compared every cycle against a per-request schedule model, plus literal pins.
module tb_sprite_layer_arbiter;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int IW   = 4;
    localparam int LW   = 2;
    localparam int MAXC = 4096;
    localparam logic [IW-1:0] TR = 4'hB;

    logic                Clk = 1'b0;
    logic                Reset_n;
    logic                pix_req;
    logic [N-1:0]        layer_hit;
    logic [N*AW-1:0]     layer_addr;

    logic [1:0]          rom_rd, pix_valid, pix_opaque, busy, req_drop;
    logic [1:0][AW-1:0]  rom_addr;
    logic [1:0][IW-1:0]  rom_idx, pal_idx;
    logic [1:0][LW-1:0]  pal_layer;
`ifdef SPRITE_ARB_DROP_CNT_EN
    logic [1:0][15:0]    drop_cnt;
`endif

    logic [IW-1:0]       mem [1024];
    logic [IW-1:0]       pipe0;
    logic [1:0][IW-1:0]  pipe1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ROM models with 1 and 2 cycles of read latency.
    always @(posedge Clk) begin
        pipe0    <= rom_rd[0] ? mem[rom_addr[0]] : '0;
        pipe1[0] <= rom_rd[1] ? mem[rom_addr[1]] : '0;
        pipe1[1] <= pipe1[0];
    end
    assign rom_idx[0] = pipe0;
    assign rom_idx[1] = pipe1[1];

    sprite_layer_arbiter #(.ROM_LAT(1)) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .pix_req(pix_req), .layer_hit(layer_hit),
        .layer_addr(layer_addr), .rom_rd(rom_rd[0]), .rom_addr(rom_addr[0]),
        .rom_idx(rom_idx[0]), .pix_valid(pix_valid[0]), .pix_opaque(pix_opaque[0]),
        .pal_idx(pal_idx[0]), .pal_layer(pal_layer[0]), .busy(busy[0]),
        .req_drop(req_drop[0])
`ifdef SPRITE_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt[0])
`endif
    );

    sprite_layer_arbiter #(.ROM_LAT(2)) u_dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .pix_req(pix_req), .layer_hit(layer_hit),
        .layer_addr(layer_addr), .rom_rd(rom_rd[1]), .rom_addr(rom_addr[1]),
        .rom_idx(rom_idx[1]), .pix_valid(pix_valid[1]), .pix_opaque(pix_opaque[1]),
        .pal_idx(pal_idx[1]), .pal_layer(pal_layer[1]), .busy(busy[1]),
        .req_drop(req_drop[1])
`ifdef SPRITE_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt[1])
`endif
    );

    // Expected per-cycle schedule, filled when a request is issued.
    bit            e_rd    [2][MAXC];
    logic [AW-1:0] e_addr  [2][MAXC];
    bit            e_valid [2][MAXC];
    bit            e_busy  [2][MAXC];
    bit            e_drop  [2][MAXC];
    bit            r_opq   [2][MAXC];
    logic [IW-1:0] r_idx   [2][MAXC];
    logic [LW-1:0] r_lay   [2][MAXC];
    int            req_c   [2];
    int            done_c  [2];
    int            m_drops [2];

    bit            c_opq   [2];
    logic [IW-1:0] c_idx   [2];
    logic [LW-1:0] c_lay   [2];
    int            vcyc    [2];
    int            vcount  [2];
    int            rdn     [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [N*AW-1:0] pack(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                             input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Walk layers in priority order: each hit layer costs one read plus the ROM latency.
    function automatic void model_req(input int i, input int c, input logic [N-1:0] hit,
                                      input logic [N*AW-1:0] addrs);
        int            k;
        int            t;
        bit            won;
        logic [AW-1:0] a;
        if (c > req_c[i] && c < done_c[i]) begin
            e_drop[i][c] = 1'b1;
            if (m_drops[i] < 65535) m_drops[i]++;
            return;
        end
        k   = 0;
        won = 1'b0;
        t   = c + 1;
        r_opq[i][MAXC-1] = 1'b0;
        for (int l = 0; l < N; l++) begin
            if (hit[l] && !won) begin
                t = c + 1 + k * (1 + lat(i));
                a = addrs[l*AW +: AW];
                e_rd[i][t]   = 1'b1;
                e_addr[i][t] = a;
                k++;
                if (mem[a] != TR) begin
                    won = 1'b1;
                    t   = c + 1 + k * (1 + lat(i));
                    r_opq[i][t] = 1'b1;
                    r_idx[i][t] = mem[a];
                    r_lay[i][t] = LW'(l);
                end
            end
        end
        t = c + 1 + k * (1 + lat(i));
        if (!won) begin
            r_opq[i][t] = 1'b0;
            r_idx[i][t] = TR;
            r_lay[i][t] = '0;
        end
        e_valid[i][t] = 1'b1;
        for (int b = c + 1; b < t; b++) e_busy[i][b] = 1'b1;
        req_c[i]  = c;
        done_c[i] = t;
    endfunction

    function automatic void model_reset(input int from);
        for (int i = 0; i < 2; i++) begin
            for (int t = from; t < MAXC; t++) begin
                e_rd[i][t]    = 1'b0;
                e_valid[i][t] = 1'b0;
                e_busy[i][t]  = 1'b0;
                e_drop[i][t]  = 1'b0;
            end
            req_c[i]   = -1;
            done_c[i]  = -1;
            m_drops[i] = 0;
        end
    endfunction

    // Compare process: all outputs of both instances on every falling edge.
    initial begin
        forever begin
            @(negedge Clk);
            for (int i = 0; i < 2; i++) begin
                if (!Reset_n) begin
                    c_opq[i] = 1'b0;
                    c_idx[i] = TR;
                    c_lay[i] = '0;
                end else if (e_valid[i][cyc]) begin
                    c_opq[i] = r_opq[i][cyc];
                    c_idx[i] = r_idx[i][cyc];
                    c_lay[i] = r_lay[i][cyc];
                end
                check($sformatf("u%0d rom_rd", i), rom_rd[i], e_rd[i][cyc] && Reset_n);
                if (e_rd[i][cyc] || !Reset_n)
                    check($sformatf("u%0d rom_addr", i), rom_addr[i], Reset_n ? e_addr[i][cyc] : '0);
                check($sformatf("u%0d pix_valid", i), pix_valid[i], e_valid[i][cyc] && Reset_n);
                check($sformatf("u%0d busy", i), busy[i], e_busy[i][cyc] && Reset_n);
                check($sformatf("u%0d req_drop", i), req_drop[i], e_drop[i][cyc] && Reset_n);
                check($sformatf("u%0d pix_opaque", i), pix_opaque[i], c_opq[i]);
                check($sformatf("u%0d pal_idx", i), pal_idx[i], c_idx[i]);
                check($sformatf("u%0d pal_layer", i), pal_layer[i], c_lay[i]);
`ifdef SPRITE_ARB_DROP_CNT_EN
                check($sformatf("u%0d drop_cnt", i), drop_cnt[i], m_drops[i]);
`endif
                if (pix_valid[i] === 1'b1) begin
                    vcyc[i] = cyc;
                    vcount[i]++;
                end
                if (rom_rd[i] === 1'b1) rdn[i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Request pulse for one cycle; inputs are scrambled afterwards so only latched copies matter.
    task automatic send(input logic [N-1:0] hit, input logic [N*AW-1:0] addrs, output int c);
        c          = cyc;
        pix_req    = 1'b1;
        layer_hit  = hit;
        layer_addr = addrs;
        model_req(0, c, hit, addrs);
        model_req(1, c, hit, addrs);
        tick(1);
        pix_req    = 1'b0;
        layer_hit  = ~hit;
        layer_addr = ~addrs;
    endtask

    int c;
    int c2;
    int r0;
    int r1;
    int v0;
    int v1;

    initial begin
        Reset_n    = 1'b0;
        pix_req    = 1'b0;
        layer_hit  = '0;
        layer_addr = '0;
        for (int a = 0; a < 1024; a++) mem[a] = TR;
        for (int i = 0; i < 2; i++) begin
            req_c[i]   = -1;
            done_c[i]  = -1;
            m_drops[i] = 0;
            vcyc[i]    = 0;
            vcount[i]  = 0;
            rdn[i]     = 0;
        end
        tick(3);
        check("reset pal_idx", pal_idx[0], TR);
        check("reset busy", busy[0], 1'b0);
        Reset_n = 1'b1;
        tick(2);

        // Single opaque layer 0.
        mem[10'h010] = 4'h3;
        r0 = rdn[0];
        send(4'b0001, pack(10'h010, 10'h3F0, 10'h3F1, 10'h3F2), c);
        tick(8);
        check("t1 lat u0", vcyc[0] - c, 3);
        check("t1 lat u1", vcyc[1] - c, 4);
        check("t1 pal_idx", pal_idx[0], 4'h3);
        check("t1 pal_layer", pal_layer[0], 2'd0);
        check("t1 opaque", pix_opaque[0], 1'b1);
        check("t1 reads", rdn[0] - r0, 1);

        // Layers 1 and 3 hit; layer 1 transparent, layer 3 wins. Non-hit layers hold opaque data.
        mem[10'h001] = 4'h5;
        mem[10'h032] = 4'h2;
        mem[10'h043] = 4'h7;
        r0 = rdn[0];
        r1 = rdn[1];
        send(4'b1010, pack(10'h001, 10'h021, 10'h032, 10'h043), c);
        tick(10);
        check("t2 lat u0", vcyc[0] - c, 5);
        check("t2 lat u1", vcyc[1] - c, 7);
        check("t2 pal_idx", pal_idx[0], 4'h7);
        check("t2 pal_layer", pal_layer[0], 2'd3);
        check("t2 reads u0", rdn[0] - r0, 2);
        check("t2 reads u1", rdn[1] - r1, 2);

        // No hits: background after one cycle, no ROM traffic.
        r0 = rdn[0];
        send(4'b0000, pack(10'h001, 10'h010, 10'h032, 10'h043), c);
        tick(3);
        check("t3 lat u0", vcyc[0] - c, 1);
        check("t3 lat u1", vcyc[1] - c, 1);
        check("t3 opaque", pix_opaque[0], 1'b0);
        check("t3 pal_idx", pal_idx[0], TR);
        check("t3 pal_layer", pal_layer[0], 2'd0);
        check("t3 reads", rdn[0] - r0, 0);

        // All four layers transparent.
        r1 = rdn[1];
        send(4'b1111, pack(10'h100, 10'h101, 10'h102, 10'h103), c);
        tick(16);
        check("t4 lat u0", vcyc[0] - c, 9);
        check("t4 lat u1", vcyc[1] - c, 13);
        check("t4 opaque u1", pix_opaque[1], 1'b0);
        check("t4 reads u1", rdn[1] - r1, 4);

        // Request dropped in WAIT, then a back-to-back request in u0's DONE cycle.
        mem[10'h200] = 4'h9;
        send(4'b0100, pack(10'h001, 10'h021, 10'h200, 10'h043), c);
        tick(1);
        pix_req   = 1'b1;
        layer_hit = 4'b0001;
        model_req(0, cyc, 4'b0001, pack(10'h010, 10'h010, 10'h010, 10'h010));
        model_req(1, cyc, 4'b0001, pack(10'h010, 10'h010, 10'h010, 10'h010));
        layer_addr = pack(10'h010, 10'h010, 10'h010, 10'h010);
        #1;
        check("t5 drop u0", req_drop[0], 1'b1);
        tick(1);
        pix_req = 1'b0;
        send(4'b0001, pack(10'h010, 10'h3F0, 10'h3F1, 10'h3F2), c2);
        check("t5 b2b busy u0", busy[0], 1'b1);
        tick(10);
        check("t5 b2b lat u0", vcyc[0] - c2, 3);
        check("t5 pal_idx u0", pal_idx[0], 4'h3);
        check("t5 pal_idx u1", pal_idx[1], 4'h9);
        check("t5 pal_layer u1", pal_layer[1], 2'd2);
`ifdef SPRITE_ARB_DROP_CNT_EN
        check("t5 drop_cnt u0", drop_cnt[0], 16'd1);
        check("t5 drop_cnt u1", drop_cnt[1], 16'd2);
`endif

        // Reset asserted in WAIT: immediate reset outputs, fetch abandoned.
        send(4'b1111, pack(10'h100, 10'h101, 10'h102, 10'h103), c);
        tick(1);
        Reset_n = 1'b0;
        model_reset(cyc);
        #1;
        check("t6 rst rom_rd", rom_rd[0], 1'b0);
        check("t6 rst busy u0", busy[0], 1'b0);
        check("t6 rst busy u1", busy[1], 1'b0);
        check("t6 rst pal_idx", pal_idx[0], TR);
        check("t6 rst opaque", pix_opaque[1], 1'b0);
        v0 = vcount[0];
        v1 = vcount[1];
        tick(2);
        Reset_n = 1'b1;
        tick(20);
        check("t6 no valid u0", vcount[0] - v0, 0);
        check("t6 no valid u1", vcount[1] - v1, 0);
`ifdef SPRITE_ARB_DROP_CNT_EN
        check("t6 drop_cnt", drop_cnt[0], 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
